// File: rtl/bk_bus_ctrl.sv
// bk_bus_ctrl: CPU bus cycle controller for the BK bus.
// Decodes RAM/ROM/register space, serves IAK vectors, times out slow replies.
module bk_bus_ctrl #(
    parameter int         NIRQ    = 2,
    parameter int         TIMEOUT = 15,
    parameter logic [7:0] DEF_VEC = 8'o000
) (
    input  logic                clk,
    input  logic                p_reset,
    input  logic                cpu_sync,
    input  logic                cpu_din,
    input  logic                cpu_dout,
    input  logic                cpu_wtbt,
    input  logic                cpu_iako,
    input  logic [15:0]         cpu_addr,
    input  logic [15:0]         cpu_dato,
    input  logic [2:0]          cpu_pri,
    output logic [15:0]         cpu_dati,
    output logic                cpu_rply,
    output logic                cpu_err,
    output logic                cpu_virq,
    output logic                mem_rd,
    output logic                mem_wt,
    output logic                mem_byte,
    output logic [15:0]         mem_addr,
    output logic [15:0]         mem_wdata,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_rdy,
    output logic                reg_rd,
    output logic                reg_wt,
    output logic [6:0]          reg_addr,
    output logic [15:0]         reg_wdata,
    input  logic [15:0]         reg_rdata,
    input  logic                reg_bad,
    input  logic [NIRQ-1:0]     irq_req,
    input  logic [8*NIRQ-1:0]   irq_vec,
    output logic [NIRQ-1:0]     irq_ack
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_MEM, ST_REG, ST_REPLY, ST_ERR
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t          state, state_nx;
    logic            sync_d, sync_ok;
    logic [7:0]      cnt;
    logic [15:0]     addr_q;
    logic            wtbt_q, wr_q;
    logic [15:0]     dati_q;
    logic [NIRQ-1:0] ack_q;

    logic            sync_rise, sync_fall, tmo;
    logic            sel_reg, sel_rom, odd_byte;
    logic [NIRQ-1:0] irq_pick;
    logic [7:0]      vec_pick;
    logic [15:0]     wdata, mem_fmt, reg_fmt;

    function automatic logic [15:0] fmt_rd(
        input logic [15:0] d,
        input logic        bsel,
        input logic        odd
    );
        unique case (1'b1)
            !bsel:  fmt_rd = d;
            odd:    fmt_rd = {8'h00, d[15:8]};
            default: fmt_rd = {8'h00, d[7:0]};
        endcase
    endfunction

    // sync_ok blocks a held-high sync from looking like a new cycle after reset
    assign sync_rise = cpu_sync & ~sync_d & sync_ok;
    assign sync_fall = ~cpu_sync & sync_d;
    assign tmo       = (cnt + 8'd1) == TMO;

    assign sel_reg  = addr_q[15:7] == 9'h1FF;
    assign sel_rom  = addr_q[15] & ~sel_reg;
    assign odd_byte = wtbt_q & addr_q[0];
    assign wdata    = odd_byte ? {cpu_dato[7:0], cpu_dato[7:0]} : cpu_dato;
    assign mem_fmt  = fmt_rd(mem_rdata, wtbt_q, addr_q[0]);
    assign reg_fmt  = fmt_rd(reg_rdata, wtbt_q, addr_q[0]);

    // Downward scan so the lowest pending index wins
    always_comb begin
        irq_pick = '0;
        vec_pick = DEF_VEC;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                irq_pick    = '0;
                irq_pick[i] = 1'b1;
                vec_pick    = irq_vec[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (sync_rise) state_nx = ST_WAIT;
            ST_WAIT: begin
                if (sync_fall)               state_nx = ST_IDLE;
                else if (cpu_iako & cpu_din) state_nx = ST_REPLY;
                else if (tmo)                state_nx = ST_ERR;
                else if (cpu_din | cpu_dout) begin
                    if (sel_reg)                 state_nx = ST_REG;
                    else if (sel_rom & cpu_dout) state_nx = ST_ERR;
                    else                         state_nx = ST_MEM;
                end
            end
            ST_MEM: begin
                if (sync_fall)    state_nx = ST_IDLE;
                else if (mem_rdy) state_nx = ST_REPLY;
                else if (tmo)     state_nx = ST_ERR;
            end
            ST_REG: begin
                if (sync_fall)    state_nx = ST_IDLE;
                else if (reg_bad) state_nx = ST_ERR;
                else              state_nx = ST_REPLY;
            end
            ST_REPLY: if (!cpu_din && !cpu_dout && !cpu_sync) state_nx = ST_IDLE;
            ST_ERR:   if (!cpu_sync) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge p_reset) begin
        if (p_reset) begin
            state   <= ST_IDLE;
            sync_d  <= 1'b0;
            sync_ok <= 1'b0;
            cnt     <= 8'd0;
            addr_q  <= 16'd0;
            wtbt_q  <= 1'b0;
            wr_q    <= 1'b0;
            dati_q  <= 16'd0;
            ack_q   <= '0;
        end else begin
            state  <= state_nx;
            sync_d <= cpu_sync;
            ack_q  <= '0;
            if (!cpu_sync) sync_ok <= 1'b1;
            if (state == ST_IDLE && sync_rise) begin
                addr_q <= cpu_addr;
                wtbt_q <= cpu_wtbt;
                cnt    <= 8'd0;
            end else if (state == ST_WAIT || state == ST_MEM) begin
                cnt <= cnt + 8'd1;
            end
            if (state == ST_WAIT) wr_q <= cpu_dout;
            if (state == ST_WAIT && state_nx == ST_REPLY) begin
                dati_q <= {8'h00, vec_pick};
                ack_q  <= irq_pick;
            end
            if (state == ST_MEM && state_nx == ST_REPLY && !wr_q)
                dati_q <= mem_fmt;
            if (state == ST_REG && state_nx == ST_REPLY && !wr_q)
                dati_q <= reg_fmt;
        end
    end

    assign cpu_dati  = dati_q;
    assign cpu_rply  = state == ST_REPLY;
    assign cpu_err   = state == ST_ERR;
    assign cpu_virq  = (|irq_req) & (cpu_pri == 3'd0);
    assign irq_ack   = ack_q;
    assign mem_rd    = (state == ST_MEM) & ~wr_q;
    assign mem_wt    = (state == ST_MEM) & wr_q;
    assign mem_byte  = wtbt_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata;
    assign reg_rd    = (state == ST_REG) & ~wr_q;
    assign reg_wt    = (state == ST_REG) & wr_q;
    assign reg_addr  = addr_q[6:0];
    assign reg_wdata = wdata;

endmodule

// File: tb/tb_bk_bus_ctrl.sv
// tb_bk_bus_ctrl: directed checks of bk_bus_ctrl bus cycles,
// byte lanes, errors, timeout, IAK vectors, abort and reset.
module tb_bk_bus_ctrl;

    logic        clk = 1'b0;
    logic        p_reset;
    logic        cpu_sync, cpu_din, cpu_dout, cpu_wtbt, cpu_iako;
    logic [15:0] cpu_addr, cpu_dato;
    logic [2:0]  cpu_pri;
    logic [15:0] cpu_dati;
    logic        cpu_rply, cpu_err, cpu_virq;
    logic        mem_rd, mem_wt, mem_byte;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rdy;
    logic        reg_rd, reg_wt;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic        reg_bad;
    logic [1:0]  irq_req;
    logic [15:0] irq_vec;
    logic [1:0]  irq_ack;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bk_bus_ctrl dut (
        .clk(clk), .p_reset(p_reset),
        .cpu_sync(cpu_sync), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_wtbt(cpu_wtbt), .cpu_iako(cpu_iako),
        .cpu_addr(cpu_addr), .cpu_dato(cpu_dato), .cpu_pri(cpu_pri),
        .cpu_dati(cpu_dati), .cpu_rply(cpu_rply), .cpu_err(cpu_err),
        .cpu_virq(cpu_virq),
        .mem_rd(mem_rd), .mem_wt(mem_wt), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .reg_rd(reg_rd), .reg_wt(reg_wt), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_bad(reg_bad),
        .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start(input logic [15:0] a, input logic bt);
        cpu_addr = a;
        cpu_wtbt = bt;
        cpu_sync = 1'b1;
        tick(1);
    endtask

    task automatic bus_end();
        cpu_din  = 1'b0;
        cpu_dout = 1'b0;
        cpu_iako = 1'b0;
        cpu_sync = 1'b0;
        mem_rdy  = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({cpu_dati, cpu_rply, cpu_err} !== 18'd0) begin
            bad++;
            $display("FAIL reset_cpu got %h/%b/%b want 0/0/0",
                     cpu_dati, cpu_rply, cpu_err);
        end
        total++;
        if ({mem_rd, mem_wt, reg_rd, reg_wt, irq_ack} !== 6'd0) begin
            bad++;
            $display("FAIL reset_strobes got %b want 000000",
                     {mem_rd, mem_wt, reg_rd, reg_wt, irq_ack});
        end
        tick(2);
        p_reset = 1'b0;
        tick(1);
    endtask

    task automatic test_word_read();
        bus_start(16'o001000, 1'b0);
        cpu_din = 1'b1;
        tick(1);
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'o001000) begin
            bad++;
            $display("FAIL word_rd_strobe got rd=%b a=%h want 1 0200",
                     mem_rd, mem_addr);
        end
        tick(2);
        mem_rdata = 16'h1234;
        mem_rdy   = 1'b1;
        tick(1);
        mem_rdy = 1'b0;
        total++;
        if (cpu_rply !== 1'b1 || cpu_dati !== 16'h1234) begin
            bad++;
            $display("FAIL word_read got rply=%b dati=%h want 1 1234",
                     cpu_rply, cpu_dati);
        end
        tick(2);
        total++;
        if (cpu_rply !== 1'b1) begin
            bad++;
            $display("FAIL word_rply_hold got %b want 1", cpu_rply);
        end
        bus_end();
        total++;
        if (cpu_rply !== 1'b0) begin
            bad++;
            $display("FAIL word_rply_drop got %b want 0", cpu_rply);
        end
    endtask

    task automatic test_byte_read();
        bus_start(16'o001001, 1'b1);
        cpu_din   = 1'b1;
        mem_rdata = 16'hABCD;
        mem_rdy   = 1'b1;
        tick(1);
        total++;
        if (mem_rd !== 1'b1 || mem_byte !== 1'b1) begin
            bad++;
            $display("FAIL byte_rd_strobe got rd=%b byte=%b want 1 1",
                     mem_rd, mem_byte);
        end
        tick(1);
        total++;
        if (cpu_rply !== 1'b1 || cpu_dati !== 16'h00AB) begin
            bad++;
            $display("FAIL byte_read_odd got rply=%b dati=%h want 1 00ab",
                     cpu_rply, cpu_dati);
        end
        bus_end();
        bus_start(16'o001000, 1'b1);
        cpu_din = 1'b1;
        mem_rdy = 1'b1;
        tick(2);
        total++;
        if (cpu_dati !== 16'h00CD) begin
            bad++;
            $display("FAIL byte_read_even got %h want 00cd", cpu_dati);
        end
        bus_end();
    endtask

    task automatic test_byte_write();
        bus_start(16'o001003, 1'b1);
        cpu_dato = 16'h0055;
        cpu_dout = 1'b1;
        tick(1);
        total++;
        if (mem_wt !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== 16'h5555) begin
            bad++;
            $display("FAIL byte_write_odd got wt=%b rd=%b wd=%h want 1 0 5555",
                     mem_wt, mem_rd, mem_wdata);
        end
        mem_rdy = 1'b1;
        tick(1);
        total++;
        if (cpu_rply !== 1'b1 || mem_wt !== 1'b0) begin
            bad++;
            $display("FAIL byte_write_rply got rply=%b wt=%b want 1 0",
                     cpu_rply, mem_wt);
        end
        bus_end();
        bus_start(16'o001002, 1'b1);
        cpu_dato = 16'h12AA;
        cpu_dout = 1'b1;
        tick(1);
        total++;
        if (mem_wdata !== 16'h12AA) begin
            bad++;
            $display("FAIL byte_write_even got %h want 12aa", mem_wdata);
        end
        mem_rdy = 1'b1;
        tick(1);
        bus_end();
    endtask

    task automatic test_rom_write();
        logic saw_wt;
        bus_start(16'o100000, 1'b0);
        saw_wt   = mem_wt;
        cpu_dato = 16'h7777;
        cpu_dout = 1'b1;
        tick(1);
        saw_wt = saw_wt | mem_wt;
        tick(1);
        saw_wt = saw_wt | mem_wt;
        total++;
        if (cpu_err !== 1'b1 || cpu_rply !== 1'b0 || saw_wt !== 1'b0) begin
            bad++;
            $display("FAIL rom_write got err=%b rply=%b wt=%b want 1 0 0",
                     cpu_err, cpu_rply, saw_wt);
        end
        cpu_dout = 1'b0;
        cpu_sync = 1'b0;
        tick(1);
        total++;
        if (cpu_err !== 1'b0) begin
            bad++;
            $display("FAIL rom_err_clear got %b want 0", cpu_err);
        end
    endtask

    task automatic test_reg_access();
        bus_start(16'o177700, 1'b0);
        reg_bad = 1'b1;
        cpu_din = 1'b1;
        tick(1);
        total++;
        if (reg_rd !== 1'b1 || reg_addr !== 7'h40) begin
            bad++;
            $display("FAIL reg_strobe got rd=%b a=%h want 1 40",
                     reg_rd, reg_addr);
        end
        tick(1);
        total++;
        if (cpu_err !== 1'b1 || reg_rd !== 1'b0) begin
            bad++;
            $display("FAIL reg_bad got err=%b rd=%b want 1 0",
                     cpu_err, reg_rd);
        end
        bus_end();
        reg_bad = 1'b0;
        reg_rdata = 16'hBEEF;
        bus_start(16'o177702, 1'b0);
        cpu_din = 1'b1;
        tick(2);
        total++;
        if (cpu_rply !== 1'b1 || cpu_dati !== 16'hBEEF) begin
            bad++;
            $display("FAIL reg_read got rply=%b dati=%h want 1 beef",
                     cpu_rply, cpu_dati);
        end
        bus_end();
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        bus_start(16'o002000, 1'b0);
        cpu_din = 1'b1;
        for (int k = 1; k < 15; k++) begin
            tick(1);
            early = early | cpu_err;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got %b want 0", early);
        end
        tick(1);
        total++;
        if (cpu_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_15 got %b want 1", cpu_err);
        end
        bus_end();
    endtask

    task automatic test_iak();
        irq_vec = {8'o274, 8'o060};
        irq_req = 2'b11;
        cpu_pri = 3'd4;
        #1;
        total++;
        if (cpu_virq !== 1'b0) begin
            bad++;
            $display("FAIL virq_pri4 got %b want 0", cpu_virq);
        end
        cpu_pri = 3'd0;
        #1;
        total++;
        if (cpu_virq !== 1'b1) begin
            bad++;
            $display("FAIL virq_pri0 got %b want 1", cpu_virq);
        end
        for (int t = 0; t < 3; t++) begin
            logic [1:0]  req;
            logic [15:0] exp_d;
            logic [1:0]  exp_a;
            case (t)
                0: begin req = 2'b00; exp_d = 16'o000000; exp_a = 2'b00; end
                1: begin req = 2'b11; exp_d = 16'o000060; exp_a = 2'b01; end
                default: begin req = 2'b10; exp_d = 16'o000274; exp_a = 2'b10; end
            endcase
            irq_req = req;
            bus_start(16'o000000, 1'b0);
            cpu_iako = 1'b1;
            cpu_din  = 1'b1;
            tick(1);
            total++;
            if (cpu_rply !== 1'b1 || cpu_dati !== exp_d || irq_ack !== exp_a) begin
                bad++;
                $display("FAIL iak_%0d got rply=%b dati=%h ack=%b want 1 %h %b",
                         t, cpu_rply, cpu_dati, irq_ack, exp_d, exp_a);
            end
            tick(1);
            total++;
            if (irq_ack !== 2'b00) begin
                bad++;
                $display("FAIL iak_ack_pulse_%0d got %b want 00", t, irq_ack);
            end
            bus_end();
        end
        irq_req = 2'b00;
    endtask

    task automatic test_abort();
        bus_start(16'o003000, 1'b0);
        cpu_din = 1'b1;
        tick(1);
        cpu_sync = 1'b0;
        tick(1);
        total++;
        if (mem_rd !== 1'b0 || cpu_rply !== 1'b0 || irq_ack !== 2'b00) begin
            bad++;
            $display("FAIL abort got rd=%b rply=%b ack=%b want 0 0 00",
                     mem_rd, cpu_rply, irq_ack);
        end
        bus_end();
    endtask

    task automatic test_reset_in_mem();
        bus_start(16'o001000, 1'b0);
        cpu_din = 1'b1;
        tick(1);
        p_reset = 1'b1;
        #1;
        total++;
        if ({mem_rd, cpu_rply, cpu_err, cpu_dati} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mem got rd=%b rply=%b err=%b dati=%h want 0",
                     mem_rd, cpu_rply, cpu_err, cpu_dati);
        end
        tick(1);
        p_reset = 1'b0;
        tick(2);
        total++;
        if (mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_restart got %b want 0", mem_rd);
        end
        bus_end();
        bus_start(16'o001000, 1'b0);
        cpu_din   = 1'b1;
        mem_rdata = 16'h4321;
        mem_rdy   = 1'b1;
        tick(2);
        total++;
        if (cpu_rply !== 1'b1 || cpu_dati !== 16'h4321) begin
            bad++;
            $display("FAIL reset_recover got rply=%b dati=%h want 1 4321",
                     cpu_rply, cpu_dati);
        end
        bus_end();
    endtask

    initial begin
        p_reset   = 1'b1;
        cpu_sync  = 1'b0;
        cpu_din   = 1'b0;
        cpu_dout  = 1'b0;
        cpu_wtbt  = 1'b0;
        cpu_iako  = 1'b0;
        cpu_addr  = 16'd0;
        cpu_dato  = 16'd0;
        cpu_pri   = 3'd7;
        mem_rdata = 16'd0;
        mem_rdy   = 1'b0;
        reg_rdata = 16'd0;
        reg_bad   = 1'b0;
        irq_req   = 2'b00;
        irq_vec   = 16'd0;
        test_reset();
        test_word_read();
        test_byte_read();
        test_byte_write();
        test_rom_write();
        test_reg_access();
        test_timeout();
        test_iak();
        test_abort();
        test_reset_in_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
